// File: rtl/click_sync_fifo.sv
// Two-phase click channel in, synchronised FIFO, two-phase click channel out.
// Input and output handshakes are resynchronised into the clk domain.
module click_sync_fifo #(
    parameter int DATA_WIDTH  = 7,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_req,
    input  logic [DATA_WIDTH:0]          in_data,
    output logic                         in_ack,
    output logic                         out_req,
    output logic [DATA_WIDTH:0]          out_data,
    input  logic                         out_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT} state_t;

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [DATA_WIDTH:0]    r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_in_ack;
    logic                   r_out_req;
    logic [DATA_WIDTH:0]    r_out_data;
    state_t                 r_state;
    state_t                 w_state_nxt;

    logic w_req_s;
    logic w_ack_s;
    logic w_pending;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_toggle;

    assign w_req_s   = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
    assign w_pending = w_req_s ^ r_in_ack;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_push    = w_pending && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], in_req};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], out_ack};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_in_ack <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_in_ack <= ~r_in_ack;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (!w_empty) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = WAIT;
            WAIT:    if (w_ack_s == r_out_req) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pop    = 1'b0;
        w_toggle = 1'b0;
        unique case (r_state)
            IDLE:    w_pop = !w_empty;
            SETUP:   w_toggle = 1'b1;
            WAIT:    w_pop = 1'b0;
            default: w_pop = 1'b0;
        endcase
    end

    // Data is loaded one cycle before the req edge so it is settled when seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_req  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_data <= r_mem[r_rd_ptr];
            end
            if (w_toggle) begin
                r_out_req <= ~r_out_req;
            end
        end
    end

    assign in_ack   = r_in_ack;
    assign out_req  = r_out_req;
    assign out_data = r_out_data;
    assign count    = r_count;

endmodule

// File: tb/tb_click_sync_fifo.sv
// Directed bench for click_sync_fifo: reset, latency, full/backpressure,
// streaming with wrap, simultaneous push/pop at full, mid-transfer reset.
module tb_click_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_req;
    logic [7:0] in_data;
    logic       in_ack;
    logic       out_req;
    logic [7:0] out_data;
    logic       out_ack;
    logic [2:0] count;

    int checks;
    int errors;

    click_sync_fifo #(
        .DATA_WIDTH  (7),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .out_req  (out_req),
        .out_data (out_data),
        .out_ack  (out_ack),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, output bit timed_out);
        in_data = d;
        in_req  = ~in_req;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_ack == in_req) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (in_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ack got %b want 0", in_ack);
        end
        checks++;
        if (out_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_req got %b want 0", out_req);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_data got %h want 00", out_data);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
    endtask

    task automatic test_single(input string tag);
        logic ack0;
        logic req0;
        ack0 = in_ack;
        req0 = out_req;
        in_data = 8'hA5;
        in_req  = ~in_req;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e <= 2) begin
                checks++;
                if (in_ack !== ack0) begin
                    errors++;
                    $display("FAIL %s in_ack_e%0d got %b want %b", tag, e, in_ack, ack0);
                end
            end
            if (e <= 3) begin
                checks++;
                if (out_data !== 8'h00) begin
                    errors++;
                    $display("FAIL %s out_data_e%0d got %h want 00", tag, e, out_data);
                end
            end
            if (e == 3) begin
                checks++;
                if (in_ack !== ~ack0) begin
                    errors++;
                    $display("FAIL %s in_ack_e3 got %b want %b", tag, in_ack, ~ack0);
                end
                checks++;
                if (count !== 3'd1) begin
                    errors++;
                    $display("FAIL %s count_e3 got %0d want 1", tag, count);
                end
            end
            if (e == 4) begin
                checks++;
                if (out_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL %s out_data_e4 got %h want a5", tag, out_data);
                end
                checks++;
                if (count !== 3'd0) begin
                    errors++;
                    $display("FAIL %s count_e4 got %0d want 0", tag, count);
                end
                checks++;
                if (out_req !== req0) begin
                    errors++;
                    $display("FAIL %s out_req_e4 got %b want %b", tag, out_req, req0);
                end
            end
            if (e == 5) begin
                checks++;
                if (out_req !== ~req0) begin
                    errors++;
                    $display("FAIL %s out_req_e5 got %b want %b", tag, out_req, ~req0);
                end
            end
        end
        out_ack = out_req;
        repeat (5) tick();
    endtask

    task automatic test_full;
        bit to;
        bit seen;
        logic [7:0] exp;
        send_word(8'h01, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL full_send01 timeout got 1 want 0");
        end
        for (int k = 2; k <= 5; k++) begin
            send_word(8'(k), to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL full_send%0d timeout got 1 want 0", k);
            end
        end
        tick();
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_count got %0d want 4", count);
        end
        checks++;
        if (out_data !== 8'h01) begin
            errors++;
            $display("FAIL full_out_data got %h want 01", out_data);
        end
        in_data = 8'h06;
        in_req  = ~in_req;
        repeat (10) tick();
        checks++;
        if (in_ack === in_req) begin
            errors++;
            $display("FAIL full_hold in_ack got %b want %b", in_ack, ~in_req);
        end
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_hold_count got %0d want 4", count);
        end
        // Acking frees the output stage; push of 06 must coincide with pop of 02
        out_ack = out_req;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            checks++;
            if (count !== 3'd4) begin
                errors++;
                $display("FAIL pushpop_count cyc%0d got %0d want 4", c, count);
            end
            if (in_ack == in_req) begin
                seen = 1'b1;
                checks++;
                if (out_data !== 8'h02) begin
                    errors++;
                    $display("FAIL pushpop_same_edge out_data got %h want 02", out_data);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL pushpop_accept timeout got 0 want 1");
        end
        for (int k = 2; k <= 6; k++) begin
            exp = 8'(k);
            seen = 1'b0;
            for (int c = 0; c < 30 && !seen; c++) begin
                if (out_req != out_ack) begin
                    seen = 1'b1;
                end else begin
                    tick();
                end
            end
            checks++;
            if (!seen || out_data !== exp) begin
                errors++;
                $display("FAIL drain_word%0d got %h (seen %b) want %h", k, out_data, seen, exp);
            end
            out_ack = out_req;
            tick();
        end
        repeat (5) tick();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL drain_count got %0d want 0", count);
        end
    endtask

    task automatic test_streaming;
        int sent;
        int rcvd;
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 400 && rcvd < 16; cyc++) begin
            if (in_ack == in_req && sent < 16) begin
                in_data = 8'(sent);
                in_req  = ~in_req;
                sent++;
            end
            if (out_req != out_ack) begin
                checks++;
                if (out_data !== 8'(rcvd)) begin
                    errors++;
                    $display("FAIL stream_word%0d got %h want %h", rcvd, out_data, 8'(rcvd));
                end
                out_ack = out_req;
                rcvd++;
            end
            tick();
            checks++;
            if (count > 3'd4) begin
                errors++;
                $display("FAIL stream_count got %0d want <=4", count);
            end
        end
        checks++;
        if (rcvd != 16) begin
            errors++;
            $display("FAIL stream_total got %0d want 16", rcvd);
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_mid;
        bit to;
        for (int k = 0; k < 4; k++) begin
            send_word(8'h11 + 8'(k), to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL midrst_send%0d timeout got 1 want 0", k);
            end
        end
        repeat (2) tick();
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL midrst_count got %0d want 3", count);
        end
        checks++;
        if (out_req === out_ack) begin
            errors++;
            $display("FAIL midrst_wait out_req got %b want %b", out_req, ~out_ack);
        end
        #3;
        rst_n = 1'b0;
        #1;
        test_reset();
        in_req  = 1'b0;
        out_ack = 1'b0;
        in_data = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        test_single("rerun");
        repeat (10) tick();
        checks++;
        if (out_req !== out_ack || count !== 3'd0) begin
            errors++;
            $display("FAIL midrst_stale req %b ack %b count %0d want idle empty", out_req, out_ack, count);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        in_req  = 1'b0;
        out_ack = 1'b0;
        in_data = 8'h00;
        #2;
        test_reset();
        tick();
        rst_n = 1'b1;
        test_single("single");
        test_full();
        test_streaming();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
